// File: rtl/dht11_sample_scheduler.sv
// DHT11 sample scheduler: paces conversion requests to the dht11_reader,
// times out hung reads, range-checks results, retries, and publishes only
// last-good temperature/humidity with a one-cycle strobe.
module dht11_sample_scheduler #(
  parameter int TICKS_PER_MS     = 100000,
  parameter int STARTUP_MS       = 1000,
  parameter int SAMPLE_PERIOD_MS = 2000,
  parameter int RETRY_GAP_MS     = 1000,
  parameter int MIN_GAP_MS       = 1000,
  parameter int TIMEOUT_MS       = 50,
  parameter int MAX_RETRY        = 3,
  parameter int T_MIN            = 0,
  parameter int T_MAX            = 50,
  parameter int H_MIN            = 20,
  parameter int H_MAX            = 90
) (
  input  logic       clk,
  input  logic       rst_n,            // active-high synchronous reset despite the name
  input  logic       force_read,
  output logic       dht_en,
  input  logic       dht_data_ready,
  input  logic [7:0] dht_temperature,
  input  logic [7:0] dht_humidity,
  output logic [7:0] temperature,
  output logic [7:0] humidity,
  output logic       sample_stb,
  output logic       data_valid,
  output logic       sensor_fault,
  output logic [7:0] fail_count
);

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int MS_MAX = max_int(max_int(max_int(STARTUP_MS, SAMPLE_PERIOD_MS),
                                          max_int(RETRY_GAP_MS, MIN_GAP_MS)),
                                  TIMEOUT_MS);
  localparam int MS_W = $clog2(MS_MAX + 1);
  localparam int PS_W = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
  localparam int RT_W = (MAX_RETRY > 1) ? $clog2(MAX_RETRY + 1) : 1;

  typedef enum logic [1:0] {
    ST_WAIT  = 2'd0,
    ST_REQ   = 2'd1,
    ST_CHECK = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [MS_W-1:0] ms_q, ms_d;
  logic [PS_W-1:0] presc_q, presc_d;
  logic [MS_W-1:0] target_q, target_d;
  logic            pending_q, pending_d;
  logic [RT_W-1:0] retry_q, retry_d;
  logic            ready_q;
  logic [7:0]      t_shadow_q, t_shadow_d;
  logic [7:0]      h_shadow_q, h_shadow_d;
  logic [7:0]      temp_q, temp_d;
  logic [7:0]      hum_q, hum_d;
  logic            stb_q, stb_d;
  logic            valid_q, valid_d;
  logic            fault_q, fault_d;
  logic [7:0]      fail_q, fail_d;

  // Helper nets shared by the next-state logic
  logic            tick;
  logic [MS_W-1:0] ms_inc;
  logic [RT_W-1:0] retry_inc;
  logic            ready_edge;
  logic            req_pending;
  logic            in_range;
  logic            clear_ms;
  logic            do_pass;
  logic            do_fail;

  // Registered state; rst_n high forces the power-up schedule
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q    <= ST_WAIT;
      ms_q       <= '0;
      presc_q    <= '0;
      target_q   <= MS_W'(STARTUP_MS);
      pending_q  <= 1'b0;
      retry_q    <= '0;
      ready_q    <= 1'b0;
      t_shadow_q <= '0;
      h_shadow_q <= '0;
      temp_q     <= '0;
      hum_q      <= '0;
      stb_q      <= 1'b0;
      valid_q    <= 1'b0;
      fault_q    <= 1'b0;
      fail_q     <= '0;
    end else begin
      state_q    <= state_d;
      ms_q       <= ms_d;
      presc_q    <= presc_d;
      target_q   <= target_d;
      pending_q  <= pending_d;
      retry_q    <= retry_d;
      ready_q    <= dht_data_ready;
      t_shadow_q <= t_shadow_d;
      h_shadow_q <= h_shadow_d;
      temp_q     <= temp_d;
      hum_q      <= hum_d;
      stb_q      <= stb_d;
      valid_q    <= valid_d;
      fault_q    <= fault_d;
      fail_q     <= fail_d;
    end
  end

  // Next-state logic: ms timebase, scheduling FSM, check and publish actions.
  // Compares use the post-tick ms value so a transition lands on the tick edge.
  always_comb begin
    tick        = (presc_q == PS_W'(TICKS_PER_MS - 1));
    ms_inc      = tick ? (ms_q + MS_W'(1)) : ms_q;
    retry_inc   = retry_q + RT_W'(1);
    ready_edge  = dht_data_ready & ~ready_q;
    // A force_read arriving this cycle is honoured immediately when allowed
    req_pending = pending_q | force_read;
    in_range    = (int'(t_shadow_q) >= T_MIN) && (int'(t_shadow_q) <= T_MAX) &&
                  (int'(h_shadow_q) >= H_MIN) && (int'(h_shadow_q) <= H_MAX);

    state_d    = state_q;
    ms_d       = ms_inc;
    presc_d    = tick ? '0 : (presc_q + PS_W'(1));
    target_d   = target_q;
    pending_d  = req_pending;
    retry_d    = retry_q;
    t_shadow_d = t_shadow_q;
    h_shadow_d = h_shadow_q;
    temp_d     = temp_q;
    hum_d      = hum_q;
    stb_d      = 1'b0;
    valid_d    = valid_q;
    fault_d    = fault_q;
    fail_d     = fail_q;
    clear_ms   = 1'b0;
    do_pass    = 1'b0;
    do_fail    = 1'b0;

    case (state_q)
      ST_WAIT: begin
        if ((ms_inc == target_q) ||
            (req_pending && (ms_inc >= MS_W'(MIN_GAP_MS)))) begin
          state_d   = ST_REQ;
          pending_d = 1'b0;
          clear_ms  = 1'b1;
        end
      end
      ST_REQ: begin
        // Data edge takes priority over a coincident timeout
        if (ready_edge) begin
          t_shadow_d = dht_temperature;
          h_shadow_d = dht_humidity;
          state_d    = ST_CHECK;
          clear_ms   = 1'b1;
        end else if (ms_inc == MS_W'(TIMEOUT_MS)) begin
          do_fail = 1'b1;
        end
      end
      ST_CHECK: begin
        if (in_range) begin
          do_pass = 1'b1;
        end else begin
          do_fail = 1'b1;
        end
      end
      default: begin
        state_d  = ST_WAIT;
        clear_ms = 1'b1;
      end
    endcase

    if (do_pass) begin
      temp_d   = t_shadow_q;
      hum_d    = h_shadow_q;
      stb_d    = 1'b1;
      valid_d  = 1'b1;
      fault_d  = 1'b0;
      retry_d  = '0;
      target_d = MS_W'(SAMPLE_PERIOD_MS);
      state_d  = ST_WAIT;
      clear_ms = 1'b1;
    end

    if (do_fail) begin
      fail_d = (fail_q == 8'hFF) ? fail_q : (fail_q + 8'd1);
      if (retry_inc == RT_W'(MAX_RETRY)) begin
        fault_d  = 1'b1;
        retry_d  = '0;
        target_d = MS_W'(SAMPLE_PERIOD_MS);
      end else begin
        retry_d  = retry_inc;
        target_d = MS_W'(RETRY_GAP_MS);
      end
      state_d  = ST_WAIT;
      clear_ms = 1'b1;
    end

    // Every state change restarts the ms timebase from zero
    if (clear_ms) begin
      ms_d    = '0;
      presc_d = '0;
    end
  end

  assign dht_en       = (state_q == ST_REQ);
  assign temperature  = temp_q;
  assign humidity     = hum_q;
  assign sample_stb   = stb_q;
  assign data_valid   = valid_q;
  assign sensor_fault = fault_q;
  assign fail_count   = fail_q;

endmodule

// File: tb/tb_dht11_sample_scheduler.sv
// Directed testbench for dht11_sample_scheduler using scaled-down timing
// (10 clk per ms) and a scripted reader response.
module tb_dht11_sample_scheduler;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       force_read = 1'b0;
  logic       dht_en;
  logic       dht_data_ready = 1'b0;
  logic [7:0] dht_temperature = 8'h00;
  logic [7:0] dht_humidity = 8'h00;
  logic [7:0] temperature;
  logic [7:0] humidity;
  logic       sample_stb;
  logic       data_valid;
  logic       sensor_fault;
  logic [7:0] fail_count;

  int cyc = 0;
  int n_cmp = 0;
  int n_mis = 0;

  dht11_sample_scheduler #(
    .TICKS_PER_MS    (10),
    .STARTUP_MS      (2),
    .SAMPLE_PERIOD_MS(20),
    .RETRY_GAP_MS    (5),
    .MIN_GAP_MS      (5),
    .TIMEOUT_MS      (3),
    .MAX_RETRY       (3),
    .T_MIN           (0),
    .T_MAX           (50),
    .H_MIN           (20),
    .H_MAX           (90)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .force_read     (force_read),
    .dht_en         (dht_en),
    .dht_data_ready (dht_data_ready),
    .dht_temperature(dht_temperature),
    .dht_humidity   (dht_humidity),
    .temperature    (temperature),
    .humidity       (humidity),
    .sample_stb     (sample_stb),
    .data_valid     (data_valid),
    .sensor_fault   (sensor_fault),
    .fail_count     (fail_count)
  );

  always #5 clk = ~clk;

  // Edge counter: at a negedge, cyc equals the number of posedges so far
  always @(posedge clk) cyc <= cyc + 1;

  // Hard stop in case the stimulus sequence stalls
  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, got cyc=%0d required < 50000", cyc);
    $fatal(1, "global timeout");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) @cyc %0d", tag, obs, obs, exp, exp, cyc);
    end else begin
      $display("  ok %s: %0d @cyc %0d", tag, obs, cyc);
    end
  endtask

  // Bounded wait on negedges: sel 0 = dht_en high, 1 = dht_en low, 2 = sample_stb high
  task automatic wait_for(input int sel, input int budget, input string tag, output int at);
    logic found;
    found = 1'b0;
    at = -1;
    for (int i = 0; i < budget && !found; i++) begin
      @(negedge clk);
      case (sel)
        0:       found = (dht_en === 1'b1);
        1:       found = (dht_en === 1'b0);
        default: found = (sample_stb === 1'b1);
      endcase
      if (found) at = cyc;
    end
    check_eq({tag, "_seen"}, {31'd0, found}, 32'd1);
  endtask

  // Reset pulse; returns the edge count of the last reset edge
  task automatic do_reset(output int c0);
    @(negedge clk);
    rst_n = 1'b1;
    force_read = 1'b0;
    dht_data_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    c0 = cyc;
  endtask

  // Reader model: answer 5 cycles after the request is seen
  task automatic answer(input logic [7:0] t, input logic [7:0] h, output int raise_cyc);
    repeat (5) @(negedge clk);
    dht_temperature = t;
    dht_humidity = h;
    dht_data_ready = 1'b1;
    raise_cyc = cyc;
  endtask

  task automatic count_stb(input int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (sample_stb === 1'b1) cnt++;
    end
  endtask

  initial begin
    int c0, r, f, x, s, fc, cnt;

    // ---- 1: startup, first good sample, periodic spacing ----
    do_reset(c0);
    check_eq("rst_dht_en", {31'd0, dht_en}, 32'd0);
    check_eq("rst_temperature", {24'd0, temperature}, 32'd0);
    check_eq("rst_humidity", {24'd0, humidity}, 32'd0);
    check_eq("rst_sample_stb", {31'd0, sample_stb}, 32'd0);
    check_eq("rst_data_valid", {31'd0, data_valid}, 32'd0);
    check_eq("rst_sensor_fault", {31'd0, sensor_fault}, 32'd0);
    check_eq("rst_fail_count", {24'd0, fail_count}, 32'd0);

    wait_for(0, 40, "t1_en", r);
    check_eq("t1_startup_delay", 32'(r - c0), 32'd20);
    answer(8'h19, 8'h32, x);
    wait_for(2, 10, "t1_stb", s);
    check_eq("t1_latency", 32'(s - x), 32'd2);
    check_eq("t1_temperature", {24'd0, temperature}, 32'h19);
    check_eq("t1_humidity", {24'd0, humidity}, 32'h32);
    check_eq("t1_data_valid", {31'd0, data_valid}, 32'd1);
    dht_data_ready = 1'b0;
    @(negedge clk);
    check_eq("t1_stb_width", {31'd0, sample_stb}, 32'd0);
    wait_for(0, 300, "t1_next_en", r);
    check_eq("t1_period", 32'(r - s), 32'd200);

    // ---- 2: reader never answers -> timeouts, retries, fault ----
    do_reset(c0);
    wait_for(0, 40, "t2_en", r);
    check_eq("t2_startup_delay", 32'(r - c0), 32'd20);
    f = r;
    for (int k = 1; k <= 3; k++) begin
      wait_for(1, 60, "t2_en_drop", f);
      check_eq("t2_en_high_len", 32'(f - r), 32'd30);
      check_eq("t2_fail_count", {24'd0, fail_count}, 32'(k));
      if (k < 3) begin
        check_eq("t2_no_fault_yet", {31'd0, sensor_fault}, 32'd0);
        wait_for(0, 80, "t2_retry_en", r);
        check_eq("t2_retry_gap", 32'(r - f), 32'd50);
      end
    end
    check_eq("t2_sensor_fault", {31'd0, sensor_fault}, 32'd1);
    check_eq("t2_temperature", {24'd0, temperature}, 32'd0);
    check_eq("t2_humidity", {24'd0, humidity}, 32'd0);
    check_eq("t2_data_valid", {31'd0, data_valid}, 32'd0);
    wait_for(0, 250, "t2_after_fault_en", r);
    check_eq("t2_fault_gap", 32'(r - f), 32'd200);

    // ---- 3: recovery from fault ----
    answer(8'h18, 8'h2D, x);
    wait_for(2, 10, "t3_stb", s);
    check_eq("t3_latency", 32'(s - x), 32'd2);
    check_eq("t3_fault_cleared", {31'd0, sensor_fault}, 32'd0);
    check_eq("t3_fail_count", {24'd0, fail_count}, 32'd3);
    check_eq("t3_temperature", {24'd0, temperature}, 32'h18);
    check_eq("t3_humidity", {24'd0, humidity}, 32'h2D);
    check_eq("t3_data_valid", {31'd0, data_valid}, 32'd1);
    dht_data_ready = 1'b0;

    // ---- 4: out-of-range temperature -> fail, hold outputs, retry ----
    wait_for(0, 250, "t4_en", r);
    check_eq("t4_period", 32'(r - s), 32'd200);
    answer(8'h3C, 8'h32, x);
    count_stb(4, cnt);
    check_eq("t4_no_stb", 32'(cnt), 32'd0);
    check_eq("t4_fail_count", {24'd0, fail_count}, 32'd4);
    check_eq("t4_temperature_hold", {24'd0, temperature}, 32'h18);
    check_eq("t4_humidity_hold", {24'd0, humidity}, 32'h2D);
    check_eq("t4_data_valid", {31'd0, data_valid}, 32'd1);
    check_eq("t4_no_fault", {31'd0, sensor_fault}, 32'd0);
    dht_data_ready = 1'b0;
    wait_for(0, 80, "t4_retry_en", r);
    // fail decision lands 2 edges after the raise, retry 50 cycles after that
    check_eq("t4_retry_gap", 32'(r - (x + 2)), 32'd50);

    // ---- 5: force_read deferred by min gap, then immediate ----
    answer(8'h17, 8'h30, x);
    wait_for(2, 10, "t5_stb_a", s);
    check_eq("t5_temperature", {24'd0, temperature}, 32'h17);
    dht_data_ready = 1'b0;
    while (cyc < s + 20) @(negedge clk);
    force_read = 1'b1;
    @(negedge clk);
    force_read = 1'b0;
    wait_for(0, 60, "t5_deferred_en", r);
    check_eq("t5_deferred_delay", 32'(r - s), 32'd50);
    answer(8'h16, 8'h2F, x);
    wait_for(2, 10, "t5_stb_b", s);
    check_eq("t5_humidity", {24'd0, humidity}, 32'h2F);
    dht_data_ready = 1'b0;
    while (cyc < s + 100) @(negedge clk);
    fc = cyc;
    check_eq("t5_idle_before_force", {31'd0, dht_en}, 32'd0);
    force_read = 1'b1;
    @(negedge clk);
    force_read = 1'b0;
    check_eq("t5_immediate_en", {31'd0, dht_en}, 32'd1);
    check_eq("t5_immediate_delay", 32'(cyc - fc), 32'd1);

    // ---- 6: reset mid-REQ ----
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("t6_en_dropped", {31'd0, dht_en}, 32'd0);
    check_eq("t6_data_valid", {31'd0, data_valid}, 32'd0);
    check_eq("t6_temperature", {24'd0, temperature}, 32'd0);
    check_eq("t6_fail_count", {24'd0, fail_count}, 32'd0);
    rst_n = 1'b0;
    dht_temperature = 8'h19;
    dht_humidity = 8'h32;
    dht_data_ready = 1'b1;
    count_stb(6, cnt);
    check_eq("t6_no_stb", 32'(cnt), 32'd0);
    dht_data_ready = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/dht11_sample_scheduler.md
Name: dht11_sample_scheduler

Overview:
- Sequences the DHT11 reader. It requests a conversion every SAMPLE_PERIOD_MS, or on demand.
- It enforces the sensor's minimum inter-read gap, times out hung reads, range-checks each result and retries on failure.
- It publishes only last-good temperature/humidity, with a one-cycle strobe, to the logic controller and the UART string block.
- It sits between dht11_reader and the consumers in top_coldstorage.

Parameters:
TICKS_PER_MS, 100000, clk cycles per millisecond tick
STARTUP_MS, 1000, delay from reset to first request (sensor power-up)
SAMPLE_PERIOD_MS, 2000, request spacing after a success or after a fault declaration
RETRY_GAP_MS, 1000, spacing before a retry after a failed read
MIN_GAP_MS, 1000, minimum time since last request end before a force_read is honoured
TIMEOUT_MS, 50, maximum time dht_en stays high waiting for data
MAX_RETRY, 3, consecutive failures that raise sensor_fault
T_MIN / T_MAX, 0 / 50, accepted temperature range (°C, inclusive)
H_MIN / H_MAX, 20 / 90, accepted humidity range (%RH, inclusive)

Ports:
clk  in  1  system clock, 100 MHz
rst_n  in  1  synchronous reset, active-high (despite the name)
force_read  in  1  single-cycle request for an immediate sample
dht_en  out  1  enable to dht11_reader; high only in REQ
dht_data_ready  in  1  reader done flag; the rising edge is used
dht_temperature  in  8  reader temperature byte
dht_humidity  in  8  reader humidity byte
temperature  out  8  last accepted temperature
humidity  out  8  last accepted humidity
sample_stb  out  1  one-cycle pulse when temperature/humidity update
data_valid  out  1  high once any sample has been accepted
sensor_fault  out  1  MAX_RETRY consecutive failures; cleared by next good sample
fail_count  out  8  total failures, saturating at 255

Behaviour:
- Reset (sampled on clk while rst_n=1):
  - All outputs are 0.
  - State is WAIT, ms counter is 0, target is STARTUP_MS.
  - The force_read pending flag and the retry counter are cleared.
  - Reset during REQ drops dht_en on the next edge.
- ms tick:
  - A prescaler counts 0..TICKS_PER_MS-1 and pulses a tick at wrap.
  - The prescaler restarts from 0 whenever the ms counter is cleared.
- Edge detect: a registered copy of dht_data_ready. ready_edge = ready & ~ready_q. A level already high on REQ entry is not an edge.
- force_read: sets the pending flag in any state. The flag is cleared on entry to REQ.
- WAIT state:
  - The ms counter increments on each tick.
  - Go to REQ when ms counter == target, or when pending and ms counter ≥ MIN_GAP_MS.
  - Clear the ms counter on exit.
- REQ state:
  - dht_en = 1; the ms counter increments on tick.
  - On ready_edge: latch dht_temperature/dht_humidity into shadow registers and go to CHECK.
  - Else when ms counter == TIMEOUT_MS: FAIL.
  - Edge and timeout in the same cycle: the edge wins.
- CHECK state (1 cycle): if T_MIN≤t≤T_MAX and H_MIN≤h≤H_MAX, then PASS, else FAIL.
- PASS:
  - On the next edge, temperature/humidity are loaded from the shadow registers.
  - In that same cycle: sample_stb=1, data_valid=1, sensor_fault=0, retry counter=0, target=SAMPLE_PERIOD_MS, state WAIT, ms counter 0.
  - sample_stb pulses even if the values are unchanged.
- FAIL:
  - fail_count increments, saturating at 255; the retry counter increments.
  - If the retry counter reaches MAX_RETRY: sensor_fault=1, retry counter=0, target=SAMPLE_PERIOD_MS.
  - Otherwise target=RETRY_GAP_MS.
  - Next state is WAIT with the ms counter at 0.
  - temperature, humidity and data_valid are unchanged.
- Latency: from ready_edge to sample_stb is exactly 2 clk cycles (REQ→CHECK→publish).
- Counters are sized to the maximum of the ms parameters. No wrap is possible because each compare is an equality on a monotonically increasing counter that is cleared on every state change.

Test Plan (TICKS_PER_MS=10, STARTUP_MS=2, SAMPLE_PERIOD_MS=20, RETRY_GAP_MS=5, MIN_GAP_MS=5, TIMEOUT_MS=3, MAX_RETRY=3):
1. Release reset, with the reader model answering t=0x19, h=0x32 in 5 cycles:
   - dht_en rises 20 cycles after reset.
   - sample_stb pulses 2 cycles after the ready edge; temperature=0x19, humidity=0x32, data_valid=1.
   - The next dht_en rises 200 cycles after the pulse.
2. Reader never answers:
   - dht_en stays high 30 cycles per attempt, with 50 cycles between attempts.
   - After the 3rd timeout, sensor_fault=1 and fail_count=3; outputs remain 0 and data_valid=0.
   - The next attempt comes 200 cycles later.
3. From a fault, reader answers t=0x18, h=0x2D: sensor_fault clears, sample_stb pulses, fail_count stays 3.
4. Reader returns t=0x3C (60 °C), h=0x32: FAIL, no sample_stb, outputs hold prior values, retry comes 50 cycles later.
5. force_read 20 cycles after a success is deferred until the ms counter = 5 (50 cycles after publish). force_read 100 cycles after a success fires on the next cycle.
6. Reset asserted mid-REQ: dht_en is 0 one edge later. A ready edge arriving after reset causes no sample_stb.
